// File: rtl/i2cmb_wb_sequencer.sv
// i2cmb_wb_sequencer: expands one byte-level I2C request into the iicmb Wishbone
// register sequence (CSR, SetBus, Start, address, data, Stop), pacing each command on irq.
module i2cmb_wb_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int NUM_I2C_BUSSES = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_rw,
    input  logic [6:0]               req_addr,
    input  logic [3:0]               req_bus,
    input  logic [5:0]               req_len,
    input  logic [7:0]               wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic                     done,
    output logic [1:0]               status,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);
    typedef enum logic [3:0] {S_INIT, S_IDLE, S_DPR, S_CMD, S_WAIT, S_STAT, S_WDAT, S_RDPR, S_DONE} state_t;
    localparam logic [7:0] C_WR = 8'h01, C_RDA = 8'h02, C_RDN = 8'h03;
    localparam logic [7:0] C_START = 8'h04, C_STOP = 8'h05, C_BUS = 8'h06;
    state_t state, state_n;
    logic [7:0] dpr, dpr_n, cmd, cmd_n, rd_data_n, acc_dat;
    logic [6:0] addr, addr_n;
    logic [5:0] cnt, cnt_n;
    logic [1:0] status_n, acc_adr;
    logic rw, rw_n, ad, ad_n, rd_valid_n, cyc_n, we_n, acc, acc_we, fin;
    logic [WB_ADDR_WIDTH-1:0] adr_n;
    logic [WB_DATA_WIDTH-1:0] dat_n;
    assign req_ready = state == S_IDLE || state == S_DONE;
    assign wr_ready  = state == S_WDAT;
    assign done      = state == S_DONE;
    assign fin       = cyc_o & ack_i;
    always_comb begin
        acc = 1'b0;
        acc_we = 1'b1;
        acc_adr = 2'd2;
        acc_dat = cmd;
        case (state)
            S_INIT: begin acc = 1'b1; acc_adr = 2'd0; acc_dat = 8'hC0; end
            S_DPR:  begin acc = 1'b1; acc_adr = 2'd1; acc_dat = dpr; end
            S_CMD:  acc = 1'b1;
            S_STAT: begin acc = 1'b1; acc_we = 1'b0; end
            S_RDPR: begin acc = 1'b1; acc_we = 1'b0; acc_adr = 2'd1; end
            default: acc = 1'b0;
        endcase
        // a new access only launches from an idle bus, which guarantees the gap cycle
        cyc_n = cyc_o ? !ack_i : acc;
        we_n = fin ? 1'b0 : we_o;
        adr_n = fin ? '0 : adr_o;
        dat_n = fin ? '0 : dat_o;
        if (!cyc_o && acc) begin
            we_n = acc_we;
            adr_n = WB_ADDR_WIDTH'(acc_adr);
            dat_n = WB_DATA_WIDTH'(acc_dat);
        end
        state_n = state;
        dpr_n = dpr;
        cmd_n = cmd;
        addr_n = addr;
        rw_n = rw;
        ad_n = ad;
        cnt_n = cnt;
        status_n = status;
        rd_valid_n = 1'b0;
        rd_data_n = rd_data;
        case (state)
            S_INIT: if (fin) state_n = S_IDLE;
            S_IDLE, S_DONE: begin
                state_n = S_IDLE;
                if (req_valid) begin
                    state_n = S_DPR;
                    dpr_n = {4'b0, req_bus};
                    cmd_n = C_BUS;
                    addr_n = req_addr;
                    rw_n = req_rw;
                    cnt_n = req_len > 6'd32 ? 6'd32 : req_len;
                    status_n = 2'b00;
                end
            end
            S_DPR:  if (fin) state_n = S_CMD;
            S_CMD:  if (fin) state_n = S_WAIT;
            S_WAIT: if (irq_i) state_n = S_STAT;
            S_WDAT: if (wr_valid) begin
                state_n = S_DPR;
                dpr_n = wr_data;
                cmd_n = C_WR;
            end
            S_RDPR: if (fin) begin
                rd_valid_n = 1'b1;
                rd_data_n = dat_i[7:0];
                cnt_n = cnt - 6'd1;
                state_n = S_CMD;
                cmd_n = cnt == 6'd1 ? C_STOP : cnt == 6'd2 ? C_RDN : C_RDA;
            end
            S_STAT: if (fin) begin
                if (dat_i[4] || dat_i[5]) begin
                    state_n = S_DONE;
                    status_n = dat_i[4] ? 2'b11 : 2'b10;
                end else if (dat_i[6]) begin
                    status_n = 2'b01;
                    state_n = cmd == C_STOP ? S_DONE : S_CMD;
                    cmd_n = C_STOP;
                end else if (!dat_i[7]) state_n = S_WAIT;
                else if (cmd == C_BUS) begin
                    state_n = S_CMD;
                    cmd_n = C_START;
                end else if (cmd == C_START) begin
                    state_n = S_DPR;
                    dpr_n = {addr, rw};
                    cmd_n = C_WR;
                    ad_n = 1'b1;
                end else if (cmd == C_STOP) state_n = S_DONE;
                else if (cmd != C_WR) state_n = S_RDPR;
                else if (ad) begin
                    ad_n = 1'b0;
                    state_n = (cnt == 6'd0 || rw) ? S_CMD : S_WDAT;
                    cmd_n = cnt == 6'd0 ? C_STOP : cnt == 6'd1 ? C_RDN : C_RDA;
                end else begin
                    cnt_n = cnt - 6'd1;
                    state_n = cnt == 6'd1 ? S_CMD : S_WDAT;
                    cmd_n = C_STOP;
                end
            end
            default: state_n = S_INIT;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_INIT;
            dpr <= '0;
            cmd <= '0;
            addr <= '0;
            rw <= 1'b0;
            ad <= 1'b0;
            cnt <= '0;
            status <= '0;
            rd_valid <= 1'b0;
            rd_data <= '0;
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o <= 1'b0;
            adr_o <= '0;
            dat_o <= '0;
        end else begin
            state <= state_n;
            dpr <= dpr_n;
            cmd <= cmd_n;
            addr <= addr_n;
            rw <= rw_n;
            ad <= ad_n;
            cnt <= cnt_n;
            status <= status_n;
            rd_valid <= rd_valid_n;
            rd_data <= rd_data_n;
            cyc_o <= cyc_n;
            stb_o <= cyc_n;
            we_o <= we_n;
            adr_o <= adr_n;
            dat_o <= dat_n;
        end
    end
endmodule
